// File: rtl/fb_rd_arbiter_pkg.sv
// Shared constants and encodings for the frame-buffer read arbiter.
// Image geometry, bus widths and the arbiter state/owner encodings.
package fb_rd_arbiter_pkg;

  localparam int c_img_cols    = 160;
  localparam int c_img_rows    = 120;
  localparam int c_img_pxls    = c_img_cols * c_img_rows;
  localparam int c_nb_img_pxls = 15;
  localparam int c_nb_buf      = 12;
  localparam int c_nb_burst    = 5;
  localparam int c_max_burst   = 16;

  typedef enum logic {
    st_idle  = 1'b0,
    st_burst = 1'b1
  } arb_state_t;

  typedef enum logic {
    own_disp = 1'b0,
    own_host = 1'b1
  } owner_t;

endpackage

// File: rtl/fb_burst_addr_gen.sv
// Host burst address/length counter. Loads a start address and beat count,
// then advances one pixel per step, wrapping at the end of the image.
module fb_burst_addr_gen #(
  parameter int c_img_pxls    = 19200,
  parameter int c_nb_img_pxls = 15,
  parameter int c_nb_burst    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [c_nb_img_pxls-1:0] load_addr,
  input  logic [c_nb_burst-1:0]    load_len,
  input  logic                     step,
  output logic [c_nb_img_pxls-1:0] addr,
  output logic                     last
);

  localparam logic [c_nb_img_pxls-1:0] c_addr_max = c_nb_img_pxls'(c_img_pxls - 1);

  logic [c_nb_img_pxls-1:0] addr_q;
  logic [c_nb_burst-1:0]    rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (load) begin
      addr_q <= load_addr;
      rem_q  <= load_len;
    end else if (step) begin
      addr_q <= (addr_q == c_addr_max) ? '0 : addr_q + c_nb_img_pxls'(1);
      rem_q  <= rem_q - c_nb_burst'(1);
    end
  end

  assign addr = addr_q;
  assign last = (rem_q == c_nb_burst'(1));

endmodule

// File: rtl/fb_rd_arbiter.sv
// Frame-buffer read-port arbiter: display has strict priority, host bursts
// fill the remaining cycles; a registered owner tag routes the 1-cycle read data.
module fb_rd_arbiter #(
  parameter int c_img_cols    = fb_rd_arbiter_pkg::c_img_cols,
  parameter int c_img_rows    = fb_rd_arbiter_pkg::c_img_rows,
  parameter int c_nb_img_pxls = fb_rd_arbiter_pkg::c_nb_img_pxls,
  parameter int c_nb_buf      = fb_rd_arbiter_pkg::c_nb_buf,
  parameter int c_nb_burst    = fb_rd_arbiter_pkg::c_nb_burst
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     disp_req_i,
  input  logic [c_nb_img_pxls-1:0] disp_addr_i,
  output logic                     disp_vld_o,
  output logic [c_nb_buf-1:0]      disp_data_o,
  input  logic                     host_req_i,
  input  logic [c_nb_img_pxls-1:0] host_addr_i,
  input  logic [c_nb_burst-1:0]    host_len_i,
  output logic                     host_gnt_o,
  output logic                     host_vld_o,
  output logic [c_nb_buf-1:0]      host_data_o,
  output logic                     host_done_o,
  output logic [c_nb_img_pxls-1:0] fb_addr_o,
  input  logic [c_nb_buf-1:0]      fb_data_i
);

  import fb_rd_arbiter_pkg::*;

  // state | meaning
  // IDLE  | no burst owned; a legal host request is granted here
  // BURST | host beats issue on every cycle the display leaves free
  localparam int c_pxls = c_img_cols * c_img_rows;

  arb_state_t               state_q, state_d;
  logic                     len_ok;
  logic                     host_gnt;
  logic                     disp_issue;
  logic                     host_issue;
  logic                     burst_last;
  logic [c_nb_img_pxls-1:0] host_addr;
  logic [c_nb_img_pxls-1:0] fb_addr_q, fb_addr_d;
  logic                     vld_q;
  logic                     last_q;
  owner_t                   owner_q;

  assign len_ok = (host_len_i != '0) && (host_len_i <= c_nb_burst'(c_max_burst));

  always_comb begin
    state_d    = state_q;
    host_gnt   = 1'b0;
    disp_issue = 1'b0;
    host_issue = 1'b0;
    fb_addr_d  = fb_addr_q;
    // Nothing issues or is granted while reset is held.
    if (!rst) begin
      disp_issue = disp_req_i;
      case (state_q)
        st_idle: begin
          if (host_req_i && len_ok) begin
            host_gnt = 1'b1;
            state_d  = st_burst;
          end
        end
        st_burst: begin
          if (!disp_req_i) begin
            host_issue = 1'b1;
            if (burst_last) state_d = st_idle;
          end
        end
        default: state_d = st_idle;
      endcase
      if (disp_issue)      fb_addr_d = disp_addr_i;
      else if (host_issue) fb_addr_d = host_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= st_idle;
      fb_addr_q <= '0;
      vld_q     <= 1'b0;
      owner_q   <= own_disp;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fb_addr_q <= fb_addr_d;
      vld_q     <= disp_issue | host_issue;
      owner_q   <= host_issue ? own_host : own_disp;
      last_q    <= host_issue & burst_last;
    end
  end

  fb_burst_addr_gen #(
    .c_img_pxls    (c_pxls),
    .c_nb_img_pxls (c_nb_img_pxls),
    .c_nb_burst    (c_nb_burst)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (host_gnt),
    .load_addr (host_addr_i),
    .load_len  (host_len_i),
    .step      (host_issue),
    .addr      (host_addr),
    .last      (burst_last)
  );

  // Read data returning during reset belongs to an aborted request.
  assign disp_vld_o  = vld_q & (owner_q == own_disp) & ~rst;
  assign host_vld_o  = vld_q & (owner_q == own_host) & ~rst;
  assign host_done_o = host_vld_o & last_q;
  assign host_gnt_o  = host_gnt;
  assign fb_addr_o   = fb_addr_d;
  assign disp_data_o = fb_data_i;
  assign host_data_o = fb_data_i;

endmodule

// File: tb/tb_fb_rd_arbiter.sv
// Randomized and directed bench for fb_rd_arbiter against a queue/arithmetic
// reference model of the arbitration rules and a behavioural frame buffer.
module tb_fb_rd_arbiter;

  localparam int C_PXLS = 19200;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req_i;
  logic [14:0] disp_addr_i;
  logic        disp_vld_o;
  logic [11:0] disp_data_o;
  logic        host_req_i;
  logic [14:0] host_addr_i;
  logic [4:0]  host_len_i;
  logic        host_gnt_o;
  logic        host_vld_o;
  logic [11:0] host_data_o;
  logic        host_done_o;
  logic [14:0] fb_addr_o;
  logic [11:0] fb_data_i;

  fb_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i),
    .disp_vld_o(disp_vld_o), .disp_data_o(disp_data_o),
    .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_len_i(host_len_i),
    .host_gnt_o(host_gnt_o), .host_vld_o(host_vld_o), .host_data_o(host_data_o),
    .host_done_o(host_done_o), .fb_addr_o(fb_addr_o), .fb_data_i(fb_data_i)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [0:32767];
  always @(posedge clk) fb_data_i <= mem[fb_addr_o];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model state
  bit m_busy, m_pend_vld, m_pend_host, m_pend_last;
  int m_addr, m_rem, m_pend_addr, m_last_fb;
  // expectations for the current cycle
  bit e_gnt, e_disp_vld, e_host_vld, e_done, d_iss, h_iss;
  int e_fb;
  logic [11:0] e_data;

  // observations
  logic [11:0] beats[$];
  int gnt_cyc[$];
  int done_cnt, last_done_beat, first_hvld, last_hvld, n_dvld;

  task automatic clear_in();
    rst = 1'b0; disp_req_i = 1'b0; disp_addr_i = '0;
    host_req_i = 1'b0; host_addr_i = '0; host_len_i = '0;
  endtask

  task automatic clear_obs();
    beats.delete(); gnt_cyc.delete();
    done_cnt = 0; last_done_beat = 0; first_hvld = -1; last_hvld = -1; n_dvld = 0;
  endtask

  task automatic eval();
    #1;
    e_disp_vld = !rst && m_pend_vld && !m_pend_host;
    e_host_vld = !rst && m_pend_vld && m_pend_host;
    e_done     = e_host_vld && m_pend_last;
    e_data     = mem[m_pend_addr];
    e_gnt      = !rst && !m_busy && host_req_i && host_len_i >= 1 && host_len_i <= 16;
    d_iss      = !rst && disp_req_i;
    h_iss      = !rst && !disp_req_i && m_busy;
    e_fb       = d_iss ? int'(disp_addr_i) : (h_iss ? m_addr : m_last_fb);
  endtask

  task automatic advance();
    if (host_vld_o === 1'b1) begin
      if (beats.size() == 0) first_hvld = cyc;
      beats.push_back(host_data_o);
      last_hvld = cyc;
      if (host_done_o === 1'b1) begin done_cnt++; last_done_beat = beats.size(); end
    end
    if (disp_vld_o === 1'b1) n_dvld++;
    if (host_gnt_o === 1'b1) gnt_cyc.push_back(cyc);
    if (rst) begin
      m_busy = 0; m_pend_vld = 0; m_last_fb = 0;
    end else begin
      m_pend_vld  = d_iss || h_iss;
      m_pend_host = h_iss;
      m_pend_addr = e_fb;
      m_pend_last = h_iss && m_rem == 1;
      m_last_fb   = e_fb;
      if (h_iss) begin
        m_addr = (m_addr + 1) % C_PXLS;
        m_rem--;
        if (m_rem == 0) m_busy = 0;
      end
      if (e_gnt) begin m_busy = 1; m_addr = host_addr_i; m_rem = host_len_i; end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; disp_req_i = 1'b1; disp_addr_i = 15'd55;
    host_req_i = 1'b1; host_addr_i = 15'd7; host_len_i = 5'd4;
    eval(); advance();
    eval();
    n_chk++; if (disp_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_disp_vld got=%b exp=0", disp_vld_o); end
    n_chk++; if (host_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_host_vld got=%b exp=0", host_vld_o); end
    n_chk++; if (host_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0", host_gnt_o); end
    n_chk++; if (host_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", host_done_o); end
    n_chk++; if (fb_addr_o !== 15'd0) begin n_fail++; $display("FAIL reset_fb_addr got=%0d exp=0", fb_addr_o); end
    advance();
    clear_in();
    eval();
    n_chk++; if (disp_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_disp_after got=%b exp=0", disp_vld_o); end
    n_chk++; if (host_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_host_after got=%b exp=0", host_vld_o); end
    advance();
  endtask

  task automatic test_display_only();
    clear_obs();
    for (int a = 0; a < 160; a++) begin
      disp_req_i = 1'b1; disp_addr_i = 15'(a);
      eval();
      n_chk++; if (fb_addr_o !== 15'(a)) begin n_fail++; $display("FAIL disp_fb_addr a=%0d got=%0d exp=%0d", a, fb_addr_o, a); end
      n_chk++; if (disp_vld_o !== e_disp_vld) begin n_fail++; $display("FAIL disp_vld a=%0d got=%b exp=%b", a, disp_vld_o, e_disp_vld); end
      if (e_disp_vld) begin
        n_chk++; if (disp_data_o !== e_data) begin n_fail++; $display("FAIL disp_data a=%0d got=%h exp=%h", a, disp_data_o, e_data); end
      end
      n_chk++; if (host_vld_o !== 1'b0 || host_gnt_o !== 1'b0) begin n_fail++; $display("FAIL disp_host_silent a=%0d got=%b%b exp=00", a, host_vld_o, host_gnt_o); end
      advance();
    end
    clear_in();
    eval();
    n_chk++; if (disp_vld_o !== 1'b1) begin n_fail++; $display("FAIL disp_last_vld got=%b exp=1", disp_vld_o); end
    n_chk++; if (disp_data_o !== mem[159]) begin n_fail++; $display("FAIL disp_last_data got=%h exp=%h", disp_data_o, mem[159]); end
    advance();
    eval();
    n_chk++; if (disp_vld_o !== 1'b0 || fb_addr_o !== 15'd159) begin n_fail++; $display("FAIL disp_idle_hold got=%b/%0d exp=0/159", disp_vld_o, fb_addr_o); end
    advance();
    n_chk++; if (n_dvld != 160) begin n_fail++; $display("FAIL disp_count got=%0d exp=160", n_dvld); end
  endtask

  task automatic test_host_only();
    int g;
    clear_obs();
    host_req_i = 1'b1; host_addr_i = 15'd100; host_len_i = 5'd4;
    eval();
    g = cyc;
    n_chk++; if (host_gnt_o !== 1'b1) begin n_fail++; $display("FAIL host_gnt got=%b exp=1", host_gnt_o); end
    advance();
    clear_in();
    for (int i = 0; i < 7; i++) begin
      eval();
      n_chk++; if (host_gnt_o !== 1'b0) begin n_fail++; $display("FAIL host_gnt_pulse i=%0d got=%b exp=0", i, host_gnt_o); end
      advance();
    end
    n_chk++; if (beats.size() != 4) begin n_fail++; $display("FAIL host_beats got=%0d exp=4", beats.size()); end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      n_chk++; if (beats[i] !== mem[100+i]) begin n_fail++; $display("FAIL host_data i=%0d got=%h exp=%h", i, beats[i], mem[100+i]); end
    end
    n_chk++; if (done_cnt != 1 || last_done_beat != 4) begin n_fail++; $display("FAIL host_done got=%0d@%0d exp=1@4", done_cnt, last_done_beat); end
    n_chk++; if (first_hvld != g + 2 || last_hvld != g + 5) begin n_fail++; $display("FAIL host_timing got=%0d..%0d exp=%0d..%0d", first_hvld, last_hvld, g+2, g+5); end
  endtask

  task automatic test_contention();
    int g;
    clear_obs();
    host_req_i = 1'b1; host_addr_i = 15'd0; host_len_i = 5'd8;
    eval(); g = cyc; advance();
    clear_in();
    for (int k = 0; k < 20; k++) begin
      disp_req_i = (k % 2 == 0); disp_addr_i = 15'($urandom_range(C_PXLS-1));
      eval();
      n_chk++; if (fb_addr_o !== 15'(e_fb)) begin n_fail++; $display("FAIL cont_fb_addr k=%0d got=%0d exp=%0d", k, fb_addr_o, e_fb); end
      n_chk++; if (disp_vld_o !== e_disp_vld) begin n_fail++; $display("FAIL cont_disp_vld k=%0d got=%b exp=%b", k, disp_vld_o, e_disp_vld); end
      if (e_disp_vld) begin
        n_chk++; if (disp_data_o !== e_data) begin n_fail++; $display("FAIL cont_disp_data k=%0d got=%h exp=%h", k, disp_data_o, e_data); end
      end
      n_chk++; if (host_vld_o !== e_host_vld) begin n_fail++; $display("FAIL cont_host_vld k=%0d got=%b exp=%b", k, host_vld_o, e_host_vld); end
      advance();
    end
    n_chk++; if (beats.size() != 8) begin n_fail++; $display("FAIL cont_beats got=%0d exp=8", beats.size()); end
    for (int i = 0; i < 8 && i < beats.size(); i++) begin
      n_chk++; if (beats[i] !== mem[i]) begin n_fail++; $display("FAIL cont_data i=%0d got=%h exp=%h", i, beats[i], mem[i]); end
    end
    n_chk++; if (done_cnt != 1 || last_done_beat != 8) begin n_fail++; $display("FAIL cont_done got=%0d@%0d exp=1@8", done_cnt, last_done_beat); end
    n_chk++; if (last_hvld != g + 17) begin n_fail++; $display("FAIL cont_finish got=%0d exp=%0d", last_hvld, g + 17); end
    n_chk++; if (n_dvld != 10) begin n_fail++; $display("FAIL cont_disp_count got=%0d exp=10", n_dvld); end
  endtask

  task automatic test_wrap();
    int exp_a [4];
    exp_a = '{19198, 19199, 0, 1};
    clear_obs();
    host_req_i = 1'b1; host_addr_i = 15'd19198; host_len_i = 5'd4;
    eval(); advance();
    clear_in();
    for (int i = 0; i < 6; i++) begin
      eval();
      if (i < 4) begin
        n_chk++; if (fb_addr_o !== 15'(exp_a[i])) begin n_fail++; $display("FAIL wrap_addr i=%0d got=%0d exp=%0d", i, fb_addr_o, exp_a[i]); end
      end
      advance();
    end
    n_chk++; if (beats.size() != 4) begin n_fail++; $display("FAIL wrap_beats got=%0d exp=4", beats.size()); end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      n_chk++; if (beats[i] !== mem[exp_a[i]]) begin n_fail++; $display("FAIL wrap_data i=%0d got=%h exp=%h", i, beats[i], mem[exp_a[i]]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int budget;
    clear_obs();
    host_req_i = 1'b1; host_addr_i = 15'd300; host_len_i = 5'd8;
    eval(); advance();
    clear_in();
    budget = 0;
    while (beats.size() < 2 && budget < 20) begin eval(); advance(); budget++; end
    n_chk++; if (beats.size() != 2) begin n_fail++; $display("FAIL rstmid_reach got=%0d exp=2", beats.size()); end
    rst = 1'b1;
    eval();
    n_chk++; if (host_vld_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_inflight got=%b exp=0", host_vld_o); end
    advance();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin eval(); advance(); end
    n_chk++; if (beats.size() != 2 || done_cnt != 0) begin n_fail++; $display("FAIL rstmid_abort got=%0d/%0d exp=2/0", beats.size(), done_cnt); end
    host_req_i = 1'b1; host_addr_i = 15'd5; host_len_i = 5'd3;
    eval();
    n_chk++; if (host_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_regrant got=%b exp=1", host_gnt_o); end
    advance();
    clear_in();
    for (int i = 0; i < 5; i++) begin eval(); advance(); end
    n_chk++; if (beats.size() != 5 || done_cnt != 1) begin n_fail++; $display("FAIL rstmid_after got=%0d/%0d exp=5/1", beats.size(), done_cnt); end
    if (beats.size() == 5) begin
      n_chk++; if (beats[2] !== mem[5] || beats[4] !== mem[7]) begin n_fail++; $display("FAIL rstmid_data got=%h,%h exp=%h,%h", beats[2], beats[4], mem[5], mem[7]); end
    end
  endtask

  task automatic test_illegal();
    int lens [3];
    lens = '{0, 17, 31};
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      host_req_i = 1'b1; host_addr_i = 15'd20; host_len_i = 5'(lens[i]);
      eval();
      n_chk++; if (host_gnt_o !== 1'b0) begin n_fail++; $display("FAIL illegal_gnt len=%0d got=%b exp=0", lens[i], host_gnt_o); end
      advance();
    end
    clear_in();
    for (int i = 0; i < 3; i++) begin eval(); advance(); end
    n_chk++; if (beats.size() != 0 || gnt_cyc.size() != 0) begin n_fail++; $display("FAIL illegal_quiet got=%0d/%0d exp=0/0", beats.size(), gnt_cyc.size()); end
  endtask

  task automatic test_overlap();
    clear_obs();
    host_req_i = 1'b1; host_addr_i = 15'd50; host_len_i = 5'd3;
    for (int i = 0; i < 10; i++) begin eval(); advance(); end
    clear_in();
    for (int i = 0; i < 5; i++) begin eval(); advance(); end
    n_chk++; if (gnt_cyc.size() < 2) begin n_fail++; $display("FAIL overlap_grants got=%0d exp>=2", gnt_cyc.size()); end
    else begin
      n_chk++; if (gnt_cyc[1] != gnt_cyc[0] + 4) begin n_fail++; $display("FAIL overlap_regrant got=%0d exp=%0d", gnt_cyc[1], gnt_cyc[0] + 4); end
    end
    n_chk++; if (beats.size() < 3 || beats[0] !== mem[50] || beats[2] !== mem[52]) begin n_fail++; $display("FAIL overlap_data got_beats=%0d exp>=3", beats.size()); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst         = ($urandom_range(49) == 0);
      disp_req_i  = ($urandom_range(1) == 1);
      disp_addr_i = 15'($urandom_range(C_PXLS-1));
      host_req_i  = ($urandom_range(9) < 3);
      host_addr_i = 15'($urandom_range(C_PXLS-1));
      host_len_i  = 5'($urandom_range(20));
      eval();
      n_chk++; if (host_gnt_o !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt k=%0d got=%b exp=%b", k, host_gnt_o, e_gnt); end
      n_chk++; if (fb_addr_o !== 15'(e_fb)) begin n_fail++; $display("FAIL rnd_fb_addr k=%0d got=%0d exp=%0d", k, fb_addr_o, e_fb); end
      n_chk++; if (disp_vld_o !== e_disp_vld) begin n_fail++; $display("FAIL rnd_disp_vld k=%0d got=%b exp=%b", k, disp_vld_o, e_disp_vld); end
      n_chk++; if (host_vld_o !== e_host_vld) begin n_fail++; $display("FAIL rnd_host_vld k=%0d got=%b exp=%b", k, host_vld_o, e_host_vld); end
      n_chk++; if (host_done_o !== e_done) begin n_fail++; $display("FAIL rnd_done k=%0d got=%b exp=%b", k, host_done_o, e_done); end
      if (e_disp_vld) begin
        n_chk++; if (disp_data_o !== e_data) begin n_fail++; $display("FAIL rnd_disp_data k=%0d got=%h exp=%h", k, disp_data_o, e_data); end
      end
      if (e_host_vld) begin
        n_chk++; if (host_data_o !== e_data) begin n_fail++; $display("FAIL rnd_host_data k=%0d got=%h exp=%h", k, host_data_o, e_data); end
      end
      advance();
    end
    clear_in();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 12'($urandom);
    m_busy = 0; m_pend_vld = 0; m_pend_host = 0; m_pend_last = 0;
    m_addr = 0; m_rem = 0; m_pend_addr = 0; m_last_fb = 0;
    clear_in();
    clear_obs();
    test_reset();
    test_display_only();
    test_host_only();
    test_contention();
    test_wrap();
    test_reset_mid_burst();
    test_illegal();
    test_overlap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_rd_arbiter.md
FB_RD_ARBITER -- requirements
Module: fb_rd_arbiter

Interface
REQ-001 The module SHALL have parameter c_img_cols, default 160, image columns.
REQ-002 The module SHALL have parameter c_img_rows, default 120, image rows.
REQ-003 The module SHALL have parameter c_nb_img_pxls, default 15, pixel-address width.
REQ-004 The module SHALL have parameter c_nb_buf, default 12, pixel data width (4-bit R, G, B).
REQ-005 The module SHALL have parameter c_nb_burst, default 5, host burst-length width (max burst 16).
REQ-006 The module SHALL have one clock and a synchronous, active-high reset:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
REQ-007 The module SHALL have the display requester port:
- disp_req_i, input, 1: display read request for this cycle.
- disp_addr_i, input, c_nb_img_pxls: display pixel address.
- disp_vld_o, output, 1: disp_data_o valid.
- disp_data_o, output, c_nb_buf: display pixel.
REQ-008 The module SHALL have the host requester port:
- host_req_i, input, 1: burst request.
- host_addr_i, input, c_nb_img_pxls: burst start address.
- host_len_i, input, c_nb_burst: burst length, 1..16.
- host_gnt_o, output, 1: burst accepted (1-cycle pulse).
- host_vld_o, output, 1: host_data_o valid.
- host_data_o, output, c_nb_buf: host pixel.
- host_done_o, output, 1: 1-cycle pulse with the last beat's host_vld_o.
REQ-009 The module SHALL have the frame-buffer read-port connection:
- fb_addr_o, output, c_nb_img_pxls: read address to the frame-buffer read port.
- fb_data_i, input, c_nb_buf: read data from the frame buffer, valid 1 cycle after its address.

Function
REQ-010 The module SHALL implement states IDLE and BURST.
REQ-011 In IDLE, host_req_i=1 with host_len_i in 1..16 SHALL pulse host_gnt_o, latch address and length, and move to BURST next cycle.
REQ-012 host_len_i=0 or host_len_i>16 SHALL be ignored: no grant, stay IDLE.
REQ-013 host_req_i SHALL be ignored while in BURST.
REQ-014 The display SHALL have strict priority: in any cycle with disp_req_i=1, fb_addr_o SHALL equal disp_addr_i (combinational) and no host beat issues.
REQ-015 In BURST with disp_req_i=0, the module SHALL issue fb_addr_o = current host address.
- Each issued beat increments the address and decrements the remaining count.
- The address SHALL wrap from c_img_cols*c_img_rows-1 (19199) to 0.
REQ-016 A host beat blocked by the display SHALL be retried the next free cycle; beats are never dropped or duplicated.
REQ-017 Read latency SHALL be 1 cycle:
- A 1-bit owner tag and an issue flag are registered per cycle.
- disp_vld_o or host_vld_o asserts in the following cycle, with the data output = fb_data_i.
REQ-018 Issuing the last beat SHALL return the state to IDLE.
- host_done_o pulses with that beat's host_vld_o.
- A new grant is possible in the cycle after the last issue.
REQ-019 With no requester active, fb_addr_o SHALL hold its last value, and no valid SHALL assert.
REQ-020 Data outputs SHALL be don't-care when not valid; the bench checks them only under valid.

Reset
REQ-021 rst=1 SHALL force, on the next clk edge:
- state IDLE;
- host_gnt_o, host_vld_o, host_done_o, disp_vld_o, fb_addr_o and the internal counters all 0.
REQ-022 Reset during BURST SHALL abort the burst with no host_done_o, and discard any beat in flight.
REQ-023 disp_req_i during rst SHALL produce no disp_vld_o.

Structure
REQ-024 The shared package SHALL hold:
- c_img_cols, c_img_rows, c_img_pxls;
- c_nb_img_pxls, c_nb_buf;
- the state encoding (IDLE=0, BURST=1).
REQ-025 The host address/length counter with wrap SHALL be one sub-module, fb_burst_addr_gen; arbitration and the latency tag stay in the top.

Verification
REQ-026 Display only: disp_req_i=1 at addresses 0..159 -> disp_vld_o one cycle later each, disp_data_o = memory[addr], host_* silent.
REQ-027 Host only: addr=100, len=4 -> host_gnt_o pulse; host_vld_o 4 consecutive cycles with data[100..103]; host_done_o on the 4th beat.
REQ-028 Contention: host addr=0, len=8, with disp_req_i asserted on alternate cycles -> every display read served in 1 cycle; host completes 8 in-order beats over 16 cycles; no duplicate beats.
REQ-029 Wrap: host addr=19198, len=4 -> beats from 19198, 19199, 0, 1.
REQ-030 Reset mid-burst: rst asserted after beat 2 of len=8 -> no further host_vld_o, no host_done_o; the next request is granted normally.
REQ-031 Illegal and overlapping requests:
- len=0 -> no grant.
- len=17 -> no grant.
- host_req_i held through a burst -> the second grant only in the cycle after the last issue.
